b_kem: RTL and testbench
========================

Name: b_kem

Overview:
- Keypad-matrix emulator: the row-driving end of the 4x4 scanned-keypad interface that the operator/hex keypad scanners use.
- Accepts a "press key N" request, waits for the scanner to strobe the matching column, pulls the matching row low for a set number of scan windows, releases it, then reports completion.
- Used as the keypad source in system-level benches and behind the remote-entry path. The scanner sees it exactly as it sees a physical keypad.

Parameters:
- HOLD_SCANS, 1, number of complete target-column windows the key is held (>=1).
- GAP_CYCLES, 4, all-rows-released cycles after release before done (>=1).
- TIMEOUT_CYCLES, 64, consecutive PRESS cycles with target column inactive before abort.

Ports:
- i_sys_clock  in  1  system clock.
- i_sys_reset  in  1  asynchronous, active-low reset.
- i_b_kem_keycode  in  4  key to press: [3:2] column index, [1:0] row index.
- i_b_kem_press_valid  in  1  press request.
- o_b_kem_press_ready  out  1  request accepted when valid&&ready.
- i_b_kem_keypad_column  in  4  scanner column strobe, active-low one-hot.
- o_b_kem_keypad_row  out  4  row lines to scanner, active-low; 4'b1111 = no key.
- o_b_kem_busy  out  1  high in any state except IDLE.
- o_b_kem_done  out  1  one-cycle pulse, press completed.
- o_b_kem_timeout  out  1  one-cycle pulse, press aborted.

Behaviour:
- Reset (async assert, sync release): state IDLE, row 4'b1111, ready 1, busy/done/timeout 0, counters 0.
- Target column active when column[key[3:2]]==0.
- Row output is combinational from the registered state and the live column, mirroring a physical switch. In PRESS with the target column active, row = ~(4'b0001<<key[1:0]); otherwise 4'b1111. A pressed row is therefore seen in the same cycle the column strobes.
- IDLE:
  - ready=1.
  - valid&&ready latches keycode; next state ARM.
  - valid while not ready is ignored and is not queued.
- ARM:
  - If the target column is active, wait until it goes inactive, so a partial window is never driven.
  - Then enter PRESS with window count 0 and timeout count 0.
- PRESS:
  - Each active->inactive transition of the target column increments the window count and clears the timeout count.
  - When window count reaches HOLD_SCANS, go to GAP.
  - Each cycle with the target column inactive increments the timeout count. On reaching TIMEOUT_CYCLES: pulse timeout, release rows, go to IDLE.
- GAP:
  - Rows 4'b1111 for GAP_CYCLES cycles.
  - Then pulse done for one cycle (registered, asserted with the IDLE entry); ready rises in the same cycle.
- Done and timeout never assert together.
- Latency from acceptance to done: ARM wait + HOLD_SCANS windows + GAP_CYCLES + 1.
- Column not one-hot (multiple zeros): only the target bit is examined; no error.
- Reset mid-press forces row 4'b1111 immediately (asynchronous). No done or timeout pulse is produced.
- Counter widths are $clog2(param+1), and counters saturate.

Optional Feature:
- B_KEM_PRESS_COUNT_EN defined: adds output o_b_kem_press_count[7:0], which increments on each done pulse, saturates at 255, and resets to 0.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package b_kem_pkg contains:
  - state enum {IDLE, ARM, PRESS, GAP};
  - keycode field localparams (COL_MSB/LSB, ROW_MSB/LSB);
  - named operator keycodes: ADD=4'h0, SUB=4'h1, MUL=4'h2, DIV=4'h3, NOT=4'h4, AND=4'h5, OR=4'h6, XOR=4'h7, SHR=4'h8, SHL=4'h9, ASR=4'hA, ASL=4'hB, NEG=4'hC.
- No sub-module is required. Window and timeout counting stay in the single FSM module.

Test Plan:
- Bench rotates the column 1110->1101->1011->0111, one cycle each. Request key 4'h0 with HOLD_SCANS=1 -> row 1110 exactly in the next 1110 cycle, 1111 otherwise; done pulses GAP_CYCLES+1 cycles after that window closes.
- Request 4'hD (col 3, row 1) -> row 1101 only during column 0111; no row activity on other columns; with b_op attached, keycode 4'hD and valid pulse are seen.
- Request 4'h5 accepted while column 1101 is already active -> that window is not driven (ARM); the following 1101 window drives 1101.
- Column held 1111 after accepting 4'h2 -> timeout pulses after 64 PRESS cycles; done stays 0; row stays 1111; ready returns to 1.
- Valid held high with alternating keycodes -> ready 0 while busy, second request accepted only in the done cycle; two done pulses total.
- Reset asserted during the row-active cycle -> row 1111 and ready 1 without waiting for a clock edge; no done pulse. With B_KEM_PRESS_COUNT_EN, the count is 0 after reset and 2 after two completed presses.

Source files
------------

// File: rtl/b_kem_pkg.sv
// b_kem_pkg: shared types and constants for the keypad-matrix emulator
package b_kem_pkg;
  typedef enum logic [1:0] {IDLE, ARM, PRESS, GAP} state_t;
  localparam int COL_MSB = 3;
  localparam int COL_LSB = 2;
  localparam int ROW_MSB = 1;
  localparam int ROW_LSB = 0;
  localparam logic [3:0] ADD = 4'h0;
  localparam logic [3:0] SUB = 4'h1;
  localparam logic [3:0] MUL = 4'h2;
  localparam logic [3:0] DIV = 4'h3;
  localparam logic [3:0] NOT = 4'h4;
  localparam logic [3:0] AND = 4'h5;
  localparam logic [3:0] OR  = 4'h6;
  localparam logic [3:0] XOR = 4'h7;
  localparam logic [3:0] SHR = 4'h8;
  localparam logic [3:0] SHL = 4'h9;
  localparam logic [3:0] ASR = 4'hA;
  localparam logic [3:0] ASL = 4'hB;
  localparam logic [3:0] NEG = 4'hC;
endpackage

// File: rtl/b_kem.sv
// b_kem: keypad-matrix emulator driving active-low rows against a scanned column strobe
// Ports: i_sys_clock/i_sys_reset (async active-low); keycode/press_valid/press_ready request
// handshake; keypad_column in (active-low one-hot), keypad_row out (active-low);
// busy, done pulse, timeout pulse. Optional B_KEM_PRESS_COUNT_EN adds o_b_kem_press_count[7:0].
module b_kem
  import b_kem_pkg::*;
#(
  parameter int HOLD_SCANS     = 1,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       i_sys_clock,
  input  logic       i_sys_reset,
  input  logic [3:0] i_b_kem_keycode,
  input  logic       i_b_kem_press_valid,
  output logic       o_b_kem_press_ready,
  input  logic [3:0] i_b_kem_keypad_column,
  output logic [3:0] o_b_kem_keypad_row,
`ifdef B_KEM_PRESS_COUNT_EN
  output logic [7:0] o_b_kem_press_count,
`endif
  output logic       o_b_kem_busy,
  output logic       o_b_kem_done,
  output logic       o_b_kem_timeout
);
  localparam int WW = $clog2(HOLD_SCANS + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [WW-1:0] HOLD = WW'(HOLD_SCANS);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);
  localparam logic [GW-1:0] GMAX = GW'(GAP_CYCLES);
  state_t state, state_n;
  logic [3:0] key;
  logic [WW-1:0] win, win_n;
  logic [TW-1:0] tmo, tmo_n;
  logic [GW-1:0] gap, gap_n;
  logic act, act_q, fall, done_n, tout_n;
  assign act = ~i_b_kem_keypad_column[key[COL_MSB:COL_LSB]];
  assign fall = act_q & ~act;
  // behaves like a physical switch: row follows the live column with no register delay
  assign o_b_kem_keypad_row = (state == PRESS && act) ? ~(4'b0001 << key[ROW_MSB:ROW_LSB]) : 4'b1111;
  assign o_b_kem_press_ready = state == IDLE;
  assign o_b_kem_busy = state != IDLE;
  always_comb begin
    state_n = state;
    win_n = win;
    tmo_n = tmo;
    gap_n = gap;
    done_n = 1'b0;
    tout_n = 1'b0;
    case (state)
      IDLE: state_n = i_b_kem_press_valid ? ARM : IDLE;
      // let an already-open window pass so only complete windows are driven
      ARM: if (!act) begin
        state_n = PRESS;
        win_n = '0;
        tmo_n = '0;
      end
      PRESS: if (fall) begin
        tmo_n = '0;
        win_n = (win == HOLD) ? win : win + 1'b1;
        gap_n = '0;
        state_n = (win_n == HOLD) ? GAP : PRESS;
      end else if (!act) begin
        tmo_n = (tmo == TMAX) ? tmo : tmo + 1'b1;
        tout_n = tmo_n == TMAX;
        state_n = tout_n ? IDLE : PRESS;
      end
      default: begin
        gap_n = (gap == GMAX) ? gap : gap + 1'b1;
        done_n = gap_n == GMAX;
        state_n = done_n ? IDLE : GAP;
      end
    endcase
  end
  always_ff @(posedge i_sys_clock or negedge i_sys_reset)
    if (!i_sys_reset) begin
      state <= IDLE;
      key <= '0;
      win <= '0;
      tmo <= '0;
      gap <= '0;
      act_q <= 1'b0;
      o_b_kem_done <= 1'b0;
      o_b_kem_timeout <= 1'b0;
    end else begin
      state <= state_n;
      key <= (state == IDLE && i_b_kem_press_valid) ? i_b_kem_keycode : key;
      win <= win_n;
      tmo <= tmo_n;
      gap <= gap_n;
      act_q <= act;
      o_b_kem_done <= done_n;
      o_b_kem_timeout <= tout_n;
    end
`ifdef B_KEM_PRESS_COUNT_EN
  always_ff @(posedge i_sys_clock or negedge i_sys_reset)
    if (!i_sys_reset) o_b_kem_press_count <= '0;
    else if (done_n && o_b_kem_press_count != 8'hFF) o_b_kem_press_count <= o_b_kem_press_count + 8'd1;
`endif
endmodule

// File: tb/tb_b_kem.sv
// tb_b_kem: directed self-checking bench for the keypad-matrix emulator
module tb_b_kem;
  import b_kem_pkg::*;
  typedef struct {
    logic [3:0] key;
    logic [3:0] row;
    logic [3:0] col;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] kc = 4'h0;
  logic valid = 1'b0;
  logic ready, busy, done, tmo;
  logic [3:0] col = 4'b1110;
  logic [3:0] row;
`ifdef B_KEM_PRESS_COUNT_EN
  logic [7:0] pcnt;
`endif
  logic rot = 1'b1;
  int checks = 0;
  int failures = 0;
  vec_t tbl[7];
  b_kem dut (
    .i_sys_clock(clk),
    .i_sys_reset(rst_n),
    .i_b_kem_keycode(kc),
    .i_b_kem_press_valid(valid),
    .o_b_kem_press_ready(ready),
    .i_b_kem_keypad_column(col),
    .o_b_kem_keypad_row(row),
`ifdef B_KEM_PRESS_COUNT_EN
    .o_b_kem_press_count(pcnt),
`endif
    .o_b_kem_busy(busy),
    .o_b_kem_done(done),
    .o_b_kem_timeout(tmo)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    if (rot) col = {col[2:0], col[3]};
  endtask
  task automatic issue(input logic [3:0] k);
    kc = k;
    valid = 1'b1;
    tick();
    valid = 1'b0;
  endtask
  task automatic run_press(input vec_t v);
    int act_n, dn, to, wcyc, dcyc;
    logic [3:0] rrow, rcol;
    act_n = 0; dn = 0; to = 0; wcyc = -100; dcyc = 0; rrow = 4'hF; rcol = 4'hF;
    issue(v.key);
    for (int i = 1; i <= 40 && dn == 0 && to == 0; i++) begin
      tick();
      #1;
      if (row != 4'hF) begin
        act_n++;
        wcyc = i;
        rrow = row;
        rcol = col;
      end
      if (done) begin
        dn++;
        dcyc = i;
      end
      if (tmo) to++;
    end
    chk("row_pattern", int'(rrow), int'(v.row));
    chk("row_column", int'(rcol), int'(v.col));
    chk("window_cycles", act_n, 1);
    chk("done_pulses", dn, 1);
    chk("timeout_pulses", to, 0);
    chk("done_latency", dcyc - wcyc, 6);
  endtask
  initial begin
    int bad, dj, tcyc, dn, acc, d1, a2, rb, found;
    tbl[0] = '{ADD,   4'b1110, 4'b1110};
    tbl[1] = '{4'hD,  4'b1101, 4'b0111};
    tbl[2] = '{AND,   4'b1101, 4'b1101};
    tbl[3] = '{ASR,   4'b1011, 4'b1011};
    tbl[4] = '{4'hF,  4'b0111, 4'b0111};
    tbl[5] = '{NEG,   4'b1110, 4'b0111};
    tbl[6] = '{OR,    4'b1011, 4'b1101};
    #2;
    chk("reset_row", int'(row), 4'hF);
    chk("reset_ready", int'(ready), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_timeout", int'(tmo), 0);
`ifdef B_KEM_PRESS_COUNT_EN
    chk("reset_count", int'(pcnt), 0);
`endif
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    for (int e = 0; e < 7; e++) run_press(tbl[e]);
    // column already strobing the target when the request is accepted
    rot = 1'b0;
    col = 4'b1101;
    issue(AND);
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      if (row != 4'hF) bad++;
    end
    chk("arm_partial_window", bad, 0);
    tick();
    col = 4'hF;
    #1;
    chk("arm_gap_row", int'(row), 4'hF);
    tick();
    col = 4'b1101;
    #1;
    chk("arm_next_window", int'(row), 4'b1101);
    dj = 0;
    for (int j = 1; j <= 10 && dj == 0; j++) begin
      tick();
      col = 4'hF;
      #1;
      if (done) dj = j;
    end
    chk("arm_done_latency", dj, 6);
    // column never strobes: abort after the timeout budget
    issue(MUL);
    tcyc = 0; dn = 0; rb = 0;
    for (int i = 1; i <= 70; i++) begin
      tick();
      #1;
      if (row != 4'hF) rb++;
      if (done) dn++;
      if (tmo && tcyc == 0) tcyc = i;
    end
    chk("timeout_cycle", tcyc, 65);
    chk("timeout_no_done", dn, 0);
    chk("timeout_row", rb, 0);
    chk("timeout_ready", int'(ready), 1);
    // valid held high: second request only taken in the done cycle
    rot = 1'b1;
    col = 4'b1110;
    valid = 1'b1;
    acc = 0; dn = 0; d1 = -1; a2 = -2; bad = 0; tcyc = 0;
    #1;
    for (int i = 0; i < 60 && dn < 2; i++) begin
      if (done) begin
        dn++;
        if (dn == 1) d1 = i;
        if (dn == 2) valid = 1'b0;
      end
      if (tmo) tcyc++;
      if (ready && busy) bad++;
      if (ready && valid) begin
        acc++;
        if (acc == 2) a2 = i;
      end
      kc = (i % 2 == 1) ? 4'hD : 4'h0;
      tick();
      #1;
    end
    valid = 1'b0;
    chk("held_done_count", dn, 2);
    chk("held_accept_count", acc, 2);
    chk("held_second_accept_cycle", a2, d1);
    chk("held_ready_while_busy", bad, 0);
    chk("held_timeouts", tcyc, 0);
    // asynchronous reset during an active row
    issue(ADD);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      tick();
      #1;
      if (row != 4'hF) found = 1;
    end
    chk("reset_test_row_seen", found, 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_row", int'(row), 4'hF);
    chk("async_reset_ready", int'(ready), 1);
    chk("async_reset_busy", int'(busy), 0);
`ifdef B_KEM_PRESS_COUNT_EN
    chk("async_reset_count", int'(pcnt), 0);
`endif
    tick();
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      #1;
      if (done || tmo) dn++;
    end
    chk("post_reset_no_pulse", dn, 0);
`ifdef B_KEM_PRESS_COUNT_EN
    run_press(tbl[0]);
    run_press(tbl[1]);
    chk("press_count", int'(pcnt), 2);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
